// File: rtl/audio_out_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_out_pkg
//  Description : Shared types and constants for the audio PWM output stage.
//                DATA_W  - default sample width (PWM period = 2**DATA_W)
//                PWM_MAX - last counter value of a PWM period
//                state_t - playback controller states
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_out_pkg;

  localparam int DATA_W  = 11;
  localparam int PWM_MAX = (1 << DATA_W) - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sample_fifo
//  Description : Synchronous FIFO for audio samples. Read and write pointers
//                carry one extra wrap bit so full/empty/level come straight
//                from the registered pointers.
//  Ports       : clkFPGA - clock          rst   - sync active-high reset
//                push    - write request  pop   - read request
//                wdata   - write data     rdata - head-of-queue data
//                full    - DEPTH entries  empty - no entries
//                level   - occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo #(
  parameter int DATA_W = 11,
  parameter int DEPTH  = 16
) (
  input  logic                   clkFPGA,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int c_AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [c_AW:0]     r_wr_ptr;
  logic [c_AW:0]     r_rd_ptr;
  logic              w_do_push;
  logic              w_do_pop;

  assign level = r_wr_ptr - r_rd_ptr;
  assign empty = (r_wr_ptr == r_rd_ptr);
  // Same slot index, opposite lap: writer is exactly one lap ahead.
  assign full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                 (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

  assign w_do_pop  = pop && !empty;
  // A pop frees the head slot this edge, so a write while full still lands.
  assign w_do_push = push && (!full || w_do_pop);

  assign rdata = r_mem[r_rd_ptr[c_AW-1:0]];

  always_ff @(posedge clkFPGA) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clkFPGA) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/audio_pwm_out.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pwm_out
//  Description : Buffers audio samples written by the core and plays one
//                sample per PWM period on a 1-bit PWM line.
//  Ports       : clkFPGA    - system clock     rst       - sync reset
//                sample_in  - unsigned sample  sample_wr - write strobe
//                finish     - end of program   pwm_out   - PWM output
//                fifo_full  - core must stall  fifo_level- occupancy
//                overflow   - sticky dropped write
//                underrun   - sticky empty at period end before finish
//                done       - playback complete, held until rst
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_pwm_out #(
  parameter int DATA_W = audio_out_pkg::DATA_W,
  parameter int DEPTH  = 16
) (
  input  logic                   clkFPGA,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      sample_in,
  input  logic                   sample_wr,
  input  logic                   finish,
  output logic                   pwm_out,
  output logic                   fifo_full,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  output logic                   underrun,
  output logic                   done
);

  import audio_out_pkg::*;

  localparam logic [DATA_W-1:0] c_PWM_LAST = '1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_pwm_cnt;
  logic [DATA_W-1:0] w_cnt_nxt;
  logic [DATA_W-1:0] r_duty;
  logic [DATA_W-1:0] w_rdata;
  logic              r_pwm;
  logic              w_pwm_nxt;
  logic              r_fin_seen;
  logic              r_overflow;
  logic              r_underrun;
  logic              w_pop;
  logic              w_set_underrun;
  logic              w_wr_req;
  logic              w_empty;

  // Writes are ignored altogether once playback has finished.
  assign w_wr_req = sample_wr && (r_state != DONE);

  sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clkFPGA (clkFPGA),
    .rst     (rst),
    .push    (w_wr_req),
    .pop     (w_pop),
    .wdata   (sample_in),
    .rdata   (w_rdata),
    .full    (fifo_full),
    .empty   (w_empty),
    .level   (fifo_level)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = '0;
    w_pwm_nxt      = 1'b0;
    w_pop          = 1'b0;
    w_set_underrun = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = PLAY;
        end else if (r_fin_seen) begin
          w_state_nxt = DONE;
        end
      end
      PLAY: begin
        w_cnt_nxt = r_pwm_cnt + 1'b1;
        w_pwm_nxt = (r_pwm_cnt < r_duty);
        if (r_pwm_cnt == c_PWM_LAST) begin
          if (!w_empty) begin
            w_pop = 1'b1;
          end else if (r_fin_seen) begin
            w_state_nxt = DONE;
            w_pwm_nxt   = 1'b0;
          end else begin
            // Starved: repeat the current duty for another period.
            w_set_underrun = 1'b1;
          end
        end
      end
      DONE: begin
        w_state_nxt = DONE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clkFPGA) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pwm_cnt  <= '0;
      r_duty     <= '0;
      r_pwm      <= 1'b0;
      r_fin_seen <= 1'b0;
      r_overflow <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pwm_cnt <= w_cnt_nxt;
      r_pwm     <= w_pwm_nxt;
      if (w_pop) r_duty <= w_rdata;
      if (finish) r_fin_seen <= 1'b1;
      if (w_set_underrun) r_underrun <= 1'b1;
      // Dropped only when full and the head is not leaving this same edge.
      if (w_wr_req && fifo_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign pwm_out  = r_pwm;
  assign overflow = r_overflow;
  assign underrun = r_underrun;
  assign done     = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_audio_pwm_out.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_pwm_out
//  Description : Self-checking bench for audio_pwm_out. A queue-based model of
//                the playback rules predicts every cycle's outputs into a
//                scoreboard; a monitor on the falling edge compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_pwm_out;

  import audio_out_pkg::*;

  localparam int W      = DATA_W;
  localparam int D      = 16;
  localparam int PERIOD = PWM_MAX + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr  = 1'b0;
  logic         fin = 1'b0;
  logic [W-1:0] din = '0;
  logic         o_pwm;
  logic         o_full;
  logic [4:0]   o_lvl;
  logic         o_ovf;
  logic         o_und;
  logic         o_done;

  audio_pwm_out #(.DATA_W(W), .DEPTH(D)) dut (
    .clkFPGA    (clk),
    .rst        (rst),
    .sample_in  (din),
    .sample_wr  (wr),
    .finish     (fin),
    .pwm_out    (o_pwm),
    .fifo_full  (o_full),
    .fifo_level (o_lvl),
    .overflow   (o_ovf),
    .underrun   (o_und),
    .done       (o_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pwm;
    logic       full;
    logic [4:0] lvl;
    logic       ovf;
    logic       und;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: mode 0 = waiting, 1 = playing, 2 = finished.
  int m_q[$];
  int m_mode    = 0;
  int m_phase   = 0;
  int m_duty    = 0;
  bit m_fin     = 0;
  bit m_ovf     = 0;
  bit m_und     = 0;
  bit m_pwm     = 0;
  bit m_started = 0;

  always @(posedge clk) begin : model
    bit take;
    bit accept;
    if (rst) begin
      m_q.delete();
      m_mode = 0; m_phase = 0; m_duty = 0;
      m_fin = 0; m_ovf = 0; m_und = 0; m_pwm = 0;
      m_started = 1;
    end else if (m_started) begin
      take   = (m_q.size() > 0) &&
               (m_mode == 0 || (m_mode == 1 && m_phase == PERIOD - 1));
      m_pwm  = (m_mode == 1) && (m_phase < m_duty);
      accept = wr && (m_mode != 2) && (m_q.size() < D || take);
      if (wr && m_mode != 2 && !accept) m_ovf = 1;
      if (m_mode == 1) begin
        if (m_phase == PERIOD - 1 && !take) begin
          if (m_fin) m_mode = 2;
          else       m_und  = 1;
        end
        m_phase = (m_phase + 1) % PERIOD;
      end
      if (take) begin
        m_duty = m_q.pop_front();
        if (m_mode == 0) begin
          m_mode  = 1;
          m_phase = 0;
        end
      end else if (m_mode == 0 && m_fin) begin
        m_mode = 2;
      end
      if (accept) m_q.push_back(int'(din));
      if (fin) m_fin = 1;
    end
    if (m_started)
      sb.push_back(exp_t'({m_pwm, m_q.size() == D, 5'(m_q.size()),
                           m_ovf, m_und, m_mode == 2}));
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    exp_t a;
    if (m_started) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        e = sb.pop_front();
        a = {o_pwm, o_full, o_lvl, o_ovf, o_und, o_done};
        if (a !== e) begin
          fails++;
          $display("FAIL outputs at %0t: got pwm=%b full=%b lvl=%0d ovf=%b und=%b done=%b, want pwm=%b full=%b lvl=%0d ovf=%b und=%b done=%b",
                   $time, a.pwm, a.full, a.lvl, a.ovf, a.und, a.done,
                   e.pwm, e.full, e.lvl, e.ovf, e.und, e.done);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    cyc(n);
    rst = 1'b0;
  endtask

  task automatic write(input logic [W-1:0] v);
    wr  = 1'b1;
    din = v;
    cyc(1);
    wr  = 1'b0;
    din = W'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!o_done && n < budget) begin
      cyc(1);
      n++;
    end
    tests++;
    if (!o_done) begin
      fails++;
      $display("FAIL done_timeout: done=%b after %0d cycles, want 1", o_done, n);
    end
  endtask

  initial begin
    // Reset and quiet idle period.
    do_reset(2);
    cyc(100);

    // Single mid-scale sample; starves after the first period.
    write(W'(1024));
    cyc(2 * PERIOD + 200);

    // Fill to full then one more while no pop can happen.
    while (m_phase < 20 || m_phase > PERIOD - 100) cyc(1);
    for (int i = 0; i < D + 1; i++) write(W'($urandom));
    cyc(20);

    // Reset mid-period with samples buffered.
    cyc($urandom_range(50, 500));
    do_reset(1);
    cyc(10);

    // Duty extremes.
    write(W'(0));
    write(W'(2047));
    cyc(2 * PERIOD + 100);

    // Three samples then a finish pulse; later writes are ignored.
    do_reset(2);
    for (int i = 0; i < 3; i++) write(W'($urandom));
    cyc(5);
    fin = 1'b1;
    cyc(1);
    fin = 1'b0;
    wait_done(3 * PERIOD + 200);
    for (int i = 0; i < 4; i++) write(W'($urandom));
    cyc(20);

    // Random writes with random gaps, then finish held high.
    do_reset(2);
    for (int i = 0; i < 12; i++) begin
      cyc($urandom_range(0, 600));
      write(W'($urandom));
    end
    fin = 1'b1;
    wait_done(20 * PERIOD);
    fin = 1'b0;
    cyc(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
